// File: rtl/latrsnq_bank_writer.sv
// ---------------------------------------------------------------------------
// latrsnq_bank_writer
//
// Turns valid/ready requests from a register-programming bus into phased
// stimulus for a bank of set/reset latches. Every request runs the same
// sequence: data setup, then an enable (write) or a bank clear/set pulse,
// then hold. lat_d is stable around every enable edge, and lat_e, !lat_rn
// and !lat_setn are never active at the same time.
//
// Optional feature (compile-time macro LATRSNQ_BANK_PARITY_EN):
//   When defined, lat_d gains one extra MSB carrying the even (XOR) parity
//   of the data bits. Clear-all and set-all drive that bit as 0.
//
// Ports:
//   CLK        in   rising-edge clock
//   RN         in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  block can accept a request (IDLE only)
//   req_op     in   00 write, 01 clear-all, 10 set-all, 11 no-op
//   req_addr   in   target word for a write. One bit wider than needed to
//                   index WORDS, so out-of-range addresses can be presented
//                   and flagged.
//   req_data   in   write data
//   lat_d      out  shared latch data bus (WIDTH, or WIDTH+1 with parity)
//   lat_e      out  one-hot, active-high per-word latch enables
//   lat_rn     out  bank clear, active low (held low while RN is low)
//   lat_setn   out  bank set, active low
//   busy       out  sequence in progress
//   err        out  one-cycle pulse when a write targets an address >= WORDS
//
// All outputs are registered. No combinational path runs from the request
// inputs to the outputs.
// ---------------------------------------------------------------------------
module latrsnq_bank_writer #(
    parameter int WORDS     = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int ADDR_W    = $clog2(WORDS) + 1,
`ifdef LATRSNQ_BANK_PARITY_EN
    localparam int DW       = WIDTH + 1
`else
    localparam int DW       = WIDTH
`endif
) (
    input  logic              CLK,
    input  logic              RN,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    output logic [DW-1:0]     lat_d,
    output logic [WORDS-1:0]  lat_e,
    output logic              lat_rn,
    output logic              lat_setn,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_CLEAR = 2'b01,
        OP_SET   = 2'b10,
        OP_NOP   = 2'b11
    } op_t;

    // The phase counter counts down to zero, so each phase loads length-1.
    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);
    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);

    state_t              state, state_next;
    logic [3:0]          cnt, cnt_next;
    op_t                 cap_op, op_next;
    logic [ADDR_W-1:0]   cap_addr, addr_next;
    logic [DW-1:0]       d_next;
    logic [WORDS-1:0]    e_next;
    logic                rn_next, setn_next, ready_next, busy_next, err_next;
    logic                addr_bad;

    // Builds the word placed on lat_d for a write. With parity enabled, the
    // extra MSB makes the total number of ones even.
    function automatic logic [DW-1:0] data_word(input logic [WIDTH-1:0] d);
`ifdef LATRSNQ_BANK_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    assign addr_bad = ({1'b0, req_addr} >= WORDS_L);

    // Next-state, capture and next-output logic. The outputs are derived
    // from the *next* state and the *next* captured request, then
    // registered. This way every output changes on the same edge as the
    // state it belongs to, and no request input reaches a pin
    // combinationally. Request fields are captured only at acceptance, so
    // later changes on the bus are ignored.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = cap_op;
        addr_next  = cap_addr;
        d_next     = lat_d;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    case (op_t'(req_op))
                        OP_WRITE: begin
                            if (addr_bad) begin
                                err_next = 1'b1;
                            end else begin
                                op_next    = OP_WRITE;
                                addr_next  = req_addr;
                                d_next     = data_word(req_data);
                                state_next = SETUP;
                                cnt_next   = SETUP_LD;
                            end
                        end
                        OP_CLEAR, OP_SET: begin
                            op_next    = op_t'(req_op);
                            d_next     = '0;
                            state_next = SETUP;
                            cnt_next   = SETUP_LD;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    state_next = PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    state_next = HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase

        e_next = '0;
        if (state_next == PULSE && op_next == OP_WRITE) begin
            for (int i = 0; i < WORDS; i++) begin
                if (addr_next == ADDR_W'(i)) begin
                    e_next[i] = 1'b1;
                end
            end
        end
        rn_next    = !(state_next == PULSE && op_next == OP_CLEAR);
        setn_next  = !(state_next == PULSE && op_next == OP_SET);
        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

    // State and output registers. In reset, lat_rn is driven low so that a
    // system reset also clears the latch bank. req_ready stays low until the
    // first clock edge after RN is released. An RN assertion in mid-sequence
    // drops lat_e together with asserting lat_rn. That is acceptable because
    // clear dominates inside the latch.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cap_op    <= OP_NOP;
            cap_addr  <= '0;
            lat_d     <= '0;
            lat_e     <= '0;
            lat_rn    <= 1'b0;
            lat_setn  <= 1'b1;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            cap_op    <= op_next;
            cap_addr  <= addr_next;
            lat_d     <= d_next;
            lat_e     <= e_next;
            lat_rn    <= rn_next;
            lat_setn  <= setn_next;
            req_ready <= ready_next;
            busy      <= busy_next;
            err       <= err_next;
        end
    end

endmodule
